// File: rtl/framing_pkg.sv
// framing_pkg: shared types, default sizing and pointer-width helper for the overlapping framer
package framing_pkg;

   typedef enum logic [1:0] {FILL, STREAM, WAIT_HOP} state_t;

   localparam int DEF_DATA_W    = 12;
   localparam int DEF_FRAME_LEN = 256;
   localparam int DEF_HOP       = 128;
   localparam int DEF_CNT_W     = 16;

   function automatic int ptr_w(input int depth);
      return depth < 2 ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/framing_ring_mem.sv
// framing_ring_mem: register array with one write port and one combinational read port
module framing_ring_mem #(
   parameter int W     = 12,
   parameter int DEPTH = 384,
   parameter int PTR_W = 9
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [W-1:0]     wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [W-1:0]     rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];

endmodule

// File: rtl/framing_overlap.sv
// framing_overlap: emits FRAME_LEN-sample frames every HOP input samples as a serial
// stream with first/last markers, backed by a FRAME_LEN+HOP circular buffer
module framing_overlap
   import framing_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int FRAME_LEN = DEF_FRAME_LEN,
   parameter int HOP       = DEF_HOP,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_first,
   output logic              out_last,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              overrun
);

   localparam int DEPTH = FRAME_LEN + HOP;
   localparam int PTR_W = ptr_w(DEPTH);
   localparam int C_W   = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [C_W-1:0]   FL       = C_W'(FRAME_LEN);
   localparam logic [C_W-1:0]   FL1      = C_W'(FRAME_LEN - 1);
   localparam logic [C_W-1:0]   HP       = C_W'(HOP);

   state_t           state, state_nxt;
   logic [PTR_W-1:0] wr_ptr, rd_ptr, start_ptr, start_nxt;
   logic [PTR_W:0]   start_sum;
   logic [C_W-1:0]   fill_cnt, fill_nxt, beat_cnt, hop_cnt, hop_nxt;
   logic             acc, hs, last_hs;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return p == LAST_PTR ? '0 : p + PTR_W'(1);
   endfunction

   assign acc       = in_valid && in_ready;
   assign hs        = out_valid && out_ready;
   assign last_hs   = hs && beat_cnt == FL1;
   assign fill_nxt  = fill_cnt + C_W'(acc);
   assign hop_nxt   = hop_cnt + C_W'(acc);
   assign start_sum = {1'b0, start_ptr} + (PTR_W+1)'(HOP);
   assign start_nxt = start_sum >= (PTR_W+1)'(DEPTH) ? PTR_W'(start_sum - (PTR_W+1)'(DEPTH)) : PTR_W'(start_sum);

   framing_ring_mem #(.W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
      .clk   (clk),
      .we    (acc),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (out_data)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= FILL;
      else      state <= state_nxt;

   // the next frame may begin on the very beat its HOPth new sample is written
   always_comb begin
      state_nxt = state;
      unique case (state)
         FILL:     state_nxt = fill_nxt == FL ? STREAM : FILL;
         STREAM:   state_nxt = !last_hs || hop_nxt >= HP ? STREAM : WAIT_HOP;
         WAIT_HOP: state_nxt = hop_nxt >= HP ? STREAM : WAIT_HOP;
         default:  state_nxt = FILL;
      endcase
   end

   always_comb begin
      out_valid = state == STREAM;
      out_first = out_valid && beat_cnt == '0;
      out_last  = out_valid && beat_cnt == FL1;
      in_ready  = !(state == STREAM && hop_cnt == HP);
      overrun   = in_valid && !in_ready;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         start_ptr <= '0;
         fill_cnt  <= '0;
         beat_cnt  <= '0;
         hop_cnt   <= '0;
         frame_cnt <= '0;
      end else begin
         if (acc) wr_ptr <= wrap_inc(wr_ptr);
         if (state == FILL) fill_cnt <= fill_nxt;
         hop_cnt <= state == FILL ? '0 : ((state == WAIT_HOP || last_hs) && hop_nxt >= HP) ? hop_nxt - HP : hop_nxt;
         if (hs) begin
            rd_ptr   <= last_hs ? start_nxt : wrap_inc(rd_ptr);
            beat_cnt <= last_hs ? '0 : beat_cnt + C_W'(1);
         end
         if (last_hs) begin
            start_ptr <= start_nxt;
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
      end

endmodule

// File: tb/tb_framing_overlap.sv
// tb_framing_overlap: scoreboard bench over three framer configurations (256/128, 8/8, 8/3)
module tb_framing_overlap;

   typedef struct packed {
      logic [11:0] d;
      logic        f;
      logic        l;
      logic [15:0] c;
   } exp_t;

   logic        clk = 0;
   logic        rst = 1;
   logic [11:0] din [3];
   logic        vin [3];
   logic        ordy [3];
   logic [11:0] dout [3];
   logic        in_ready [3];
   logic        out_valid [3];
   logic        out_first [3];
   logic        out_last [3];
   logic        overrun [3];
   logic [15:0] frame_cnt [3];

   exp_t        sb [3][$];
   logic        prev_stall [3];
   logic [11:0] prev_d [3];
   int          tests = 0, fails = 0, n_acc = 0, base = 0, span;

   always #5 clk = ~clk;

   genvar g;
   for (g = 0; g < 3; g++) begin : u
      framing_overlap #(
         .DATA_W(12), .FRAME_LEN(g == 0 ? 256 : 8), .HOP(g == 0 ? 128 : g == 1 ? 8 : 3), .CNT_W(16)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .in_data   (din[g]),
         .in_valid  (vin[g]),
         .in_ready  (in_ready[g]),
         .out_data  (dout[g]),
         .out_valid (out_valid[g]),
         .out_ready (ordy[g]),
         .out_first (out_first[g]),
         .out_last  (out_last[g]),
         .frame_cnt (frame_cnt[g]),
         .overrun   (overrun[g])
      );
   end

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int flen(input int k);
      return k == 0 ? 256 : 8;
   endfunction

   function automatic int hop(input int k);
      return k == 0 ? 128 : k == 1 ? 8 : 3;
   endfunction

   task automatic push_frame(input int k, input int start, input int len, input int idx);
      exp_t e;
      for (int i = 0; i < len; i++) begin
         e.d = 12'(start + i);
         e.f = i == 0;
         e.l = i == flen(k) - 1;
         e.c = 16'(idx);
         sb[k].push_back(e);
      end
   endtask

   task automatic do_reset();
      rst = 0;
      for (int k = 0; k < 3; k++) begin
         vin[k] = 0;
         ordy[k] = 0;
         din[k] = '0;
         sb[k].delete();
      end
      repeat (2) @(posedge clk);
      #1 rst = 1;
      n_acc = 0;
      base = 0;
   endtask

   // vmode 1 gaps in_valid to 1-in-4 once the first frame has filled; rmode 1 gives out_ready 1-of-3
   task automatic run(input int k, input int vmode, input int rmode, input int lim, input int drop_at, output int sp);
      int cf;
      bit acc, drop_seen;
      cf = -1;
      acc = 0;
      drop_seen = 0;
      sp = -1;
      for (int c = 0; c < 20000; c++) begin
         @(posedge clk);
         #1;
         if (acc) n_acc++;
         din[k] = 12'(base + n_acc);
         if (n_acc == flen(k) - 1) chk("fill_no_valid", out_valid[k], 0);
         if (acc && n_acc == flen(k)) chk("first_latency", out_valid[k], 1);
         if (vmode == 1 && n_acc == flen(k) + hop(k) - 1) chk("wait_idle", out_valid[k], 0);
         if (vmode == 1 && acc && n_acc == flen(k) + hop(k)) chk("wait_rise", out_valid[k], 1);
         if (cf < 0 && out_valid[k]) cf = c;
         if (sb[k].size() == 0) begin
            sp = c - cf;
            break;
         end
         vin[k] = n_acc < lim && (vmode == 0 || n_acc < flen(k) || c % 4 == 0);
         ordy[k] = rmode == 0 || c % 3 == 0;
         if (vin[k] && !in_ready[k] && !drop_seen) begin
            drop_seen = 1;
            chk("block_point", n_acc, drop_at);
         end
         acc = vin[k] && in_ready[k];
      end
      vin[k] = 0;
      ordy[k] = 0;
      chk("drained", sb[k].size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         for (int k = 0; k < 3; k++) prev_stall[k] = 0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (prev_stall[k]) begin
               chk("stall_valid", out_valid[k], 1);
               chk("stall_data", dout[k], prev_d[k]);
            end
            if (vin[k] || overrun[k]) chk("overrun", overrun[k], vin[k] && !in_ready[k]);
            if (out_valid[k] && ordy[k]) begin
               if (sb[k].size() == 0) begin
                  chk("extra_beat", 1, 0);
               end else begin
                  e = sb[k].pop_front();
                  chk("out_data", dout[k], e.d);
                  chk("out_first", out_first[k], e.f);
                  chk("out_last", out_last[k], e.l);
                  chk("frame_cnt_beat", frame_cnt[k], e.c);
               end
            end
            prev_stall[k] = out_valid[k] && !ordy[k];
            prev_d[k] = dout[k];
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         vin[k] = 0;
         ordy[k] = 0;
         din[k] = '0;
         prev_stall[k] = 0;
         prev_d[k] = '0;
      end
      #1 rst = 0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_out_valid", out_valid[k], 0);
         chk("rst_in_ready", in_ready[k], 1);
         chk("rst_frame_cnt", frame_cnt[k], 0);
         chk("rst_out_first", out_first[k], 0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1;

      // defaults, continuous ramp: three frames at starts 0, 128, 256
      for (int j = 0; j < 3; j++) push_frame(0, j * 128, 256, j);
      run(0, 0, 0, 1 << 30, 384, span);
      chk("t1_span", span, 768);
      chk("t1_frame_cnt", frame_cnt[0], 3);

      // HOP == FRAME_LEN: disjoint frames, never blocked
      do_reset();
      for (int j = 0; j < 3; j++) push_frame(1, j * 8, 8, j);
      run(1, 0, 0, 24, -1, span);
      chk("t2_span", span, 24);
      chk("t2_frame_cnt", frame_cnt[1], 3);

      // FRAME_LEN 8, HOP 3, 40 samples: starts 0,3,...,30 across the 10->0 wrap
      do_reset();
      for (int j = 0; j < 11; j++) push_frame(2, j * 3, 8, j);
      run(2, 0, 0, 40, 11, span);
      chk("t3_span", span, 88);
      chk("t3_frame_cnt", frame_cnt[2], 11);

      // defaults with out_ready 1-of-3
      do_reset();
      push_frame(0, 0, 256, 0);
      push_frame(0, 128, 256, 1);
      run(0, 0, 1, 1 << 30, 384, span);
      chk("t4_frame_cnt", frame_cnt[0], 2);

      // async reset while beat 100 of frame 1 is presented
      do_reset();
      push_frame(0, 0, 256, 0);
      push_frame(0, 128, 100, 1);
      run(0, 0, 0, 1 << 30, 384, span);
      chk("t5_pre_valid", out_valid[0], 1);
      rst = 0;
      #1;
      chk("t5_async_valid", out_valid[0], 0);
      chk("t5_async_frame_cnt", frame_cnt[0], 0);
      chk("t5_async_in_ready", in_ready[0], 1);
      @(posedge clk);
      #1 rst = 1;
      base = 1000;
      n_acc = 0;
      push_frame(0, 1000, 256, 0);
      run(0, 0, 0, 1 << 30, 384, span);
      chk("t5_frame_cnt", frame_cnt[0], 1);

      // gapped input forces WAIT_HOP between frame 0 and frame 1
      do_reset();
      push_frame(0, 0, 256, 0);
      push_frame(0, 128, 256, 1);
      run(0, 1, 0, 1 << 30, -1, span);
      chk("t6_frame_cnt", frame_cnt[0], 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/framing_overlap.md
Name: framing_overlap

Overview:
Parametrised successor to the fixed 256-sample framer. Accepts a stream of audio samples with a valid/ready handshake and emits overlapping frames of FRAME_LEN samples, hopping by HOP samples, as a serial stream with first/last markers. Sits between the ADC sample path and the windowing/FFT stage. Replaces the 256-wide parallel frame bus with a single-word streaming output.

Parameters:
DATA_W, 12, sample width in bits
FRAME_LEN, 256, samples per frame; must be at least 2
HOP, 128, new samples between frame starts; 1 <= HOP <= FRAME_LEN (HOP = FRAME_LEN gives non-overlapping frames)
CNT_W, 16, width of the frame counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_data  in  DATA_W  input sample
in_valid  in  1  in_data valid
in_ready  out  1  sample accepted when in_valid && in_ready
out_data  out  DATA_W  frame sample, oldest first
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_first  out  1  marks sample 0 of a frame; qualified by out_valid
out_last  out  1  marks sample FRAME_LEN-1; qualified by out_valid
frame_cnt  out  CNT_W  frames fully emitted; increments on the last-beat handshake; wraps at 2^CNT_W
overrun  out  1  one-cycle pulse when in_valid is high and in_ready is low

Behaviour:
- Storage: circular register array of DEPTH = FRAME_LEN+HOP words. wr_ptr and rd_ptr wrap explicitly at DEPTH-1 to 0; DEPTH is not required to be a power of two.
- Reset (rst low, asynchronous): state=FILL; all pointers, counters and frame_cnt = 0; out_valid=0, overrun=0, in_ready=1. Array contents are don't-care. Reset mid-frame abandons the frame with no partial flush.
- Write: on an accepted sample, mem[wr_ptr] <= in_data and wr_ptr advances.
- States:
  - FILL: count accepted samples. When the sample that makes the count FRAME_LEN is accepted, go to STREAM next cycle with rd_ptr = start_ptr = 0.
  - STREAM: out_valid=1 and out_data=mem[rd_ptr]. out_data is held stable while stalled. Each handshake advances rd_ptr and beat_cnt. On the last-beat handshake: start_ptr += HOP (mod DEPTH), frame_cnt++. If hop_cnt >= HOP, go straight to STREAM again (back-to-back, no gap, rd_ptr = new start_ptr) and hop_cnt -= HOP. Otherwise go to WAIT_HOP.
  - WAIT_HOP: out_valid=0. When hop_cnt reaches HOP, go to STREAM next cycle and set hop_cnt=0.
- hop_cnt counts samples accepted since the current frame's start+FRAME_LEN position. It counts in STREAM and WAIT_HOP.
- Flow control: in_ready = !(state==STREAM && hop_cnt==HOP). This blocks a write into slots still being read. With DEPTH = FRAME_LEN+HOP, writes never alias unread data of the current frame. Blocked samples are not stored, and overrun pulses for each such cycle.
- Simultaneous write and read in one cycle is legal and never targets the same slot.
- Latency: the first beat of a frame appears 1 cycle after the handshake of the completing input sample. If out_ready is held high, a frame takes exactly FRAME_LEN cycles.
- out_first = out_valid && beat_cnt==0. out_last = out_valid && beat_cnt==FRAME_LEN-1.

Decomposition:
- Package framing_pkg: state enum (FILL, STREAM, WAIT_HOP); default DATA_W/FRAME_LEN/HOP constants; a function computing pointer width ($clog2(DEPTH)).
- One sub-module, framing_ring_mem: parametrised register array with one write port and one combinational read port, no reset on data.
- Control FSM, counters and pointer wrap logic stay in framing_overlap.

Test Plan:
- Defaults, ramp input 0,1,2,… with in_valid and out_ready always high -> frame0 = 0..255, frame1 = 128..383, frame2 = 256..511; out_first/out_last on the first and last beat of each; frame_cnt = 1, 2, 3.
- HOP=FRAME_LEN=8, ramp input -> frames 0..7, 8..15, 16..23, with no sample repeated or skipped.
- FRAME_LEN=8, HOP=3 (DEPTH=11), 40-sample ramp -> frames start at 0, 3, 6, 9, …; pointer wrap at 10→0 is seamless (frame 3 = 9..16).
- Defaults, out_ready toggling 1-of-3, in_valid always high -> in_ready drops once 128 samples arrive mid-frame; overrun pulses each blocked cycle; emitted frames still match the ramp for the accepted samples; out_data is stable during stalls.
- Assert rst low during beat 100 of frame 1 -> out_valid=0 and frame_cnt=0 immediately (asynchronous); after release, a fresh FILL of 256 samples is needed before the next out_valid.
- In WAIT_HOP, in_valid gapped at 1-in-4 -> out_valid rises exactly 1 cycle after the 128th new sample handshake; out_valid stays 0 in between.
